corr_window_sequencer: RTL and testbench

Sequencing controller for the usbfsBpCorrelator probe-pair datapath. Generates jittered sample strobes and frames them into windows of 2^k samples. It also handshakes each completed window's result into the packet FIFO, stalling sampling under backpressure. Sits between the USB-side config registers and the correlator/metric pipeline, in the 48MHz domain.

---
 rtl/corr_window_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_corr_window_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_window_sequencer.sv
// ---------------------------------------------------------------------------
// corr_window_sequencer
//
// Sequencing controller for the usbfsBpCorrelator probe-pair datapath
// (48 MHz domain). It performs three jobs:
//   - generates jittered sample strobes: a base period plus a pseudo-random
//     offset taken from a 16-bit Galois LFSR,
//   - frames the strobes into windows of 2^exp samples,
//   - handshakes each finished window's result into the packet FIFO.
// Sampling stalls while a result is waiting for the FIFO.
//
// Ports
//   i_clk                  single clock
//   i_rst                  synchronous active-high reset; dominates everything
//   i_cg                   clock-gate enable; low freezes all state and outputs
//   i_cfg_enable           run request; low aborts an in-progress window
//   i_cfg_windowLengthExp  window = 2^value samples (clamped to 1..MAX)
//   i_cfg_samplePeriodM1   base sample interval minus one
//   i_cfg_sampleJitterExp  number of LFSR bits added as jitter (clamped to MAX)
//   o_sampleStrobe         one-cycle pulse: datapath captures probes
//   o_windowStart          with the first strobe of a window
//   o_windowEnd            with the last strobe of a window
//   o_rslt_valid           window result offered to the packet FIFO
//   i_rslt_ready           packet FIFO accepts the result
//   o_windowIdx            index of the window presented or being sampled
//   o_busy                 sequencer is not idle
// ---------------------------------------------------------------------------
module corr_window_sequencer #(
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int MAX_SAMPLE_PERIOD_EXP = 15,
    parameter int MAX_SAMPLE_JITTER_EXP = 8
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_cg,
    input  logic                                     i_cfg_enable,
    input  logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] i_cfg_windowLengthExp,
    input  logic [MAX_SAMPLE_PERIOD_EXP-1:0]         i_cfg_samplePeriodM1,
    input  logic [$clog2(MAX_SAMPLE_JITTER_EXP+1)-1:0] i_cfg_sampleJitterExp,
    output logic                                     o_sampleStrobe,
    output logic                                     o_windowStart,
    output logic                                     o_windowEnd,
    output logic                                     o_rslt_valid,
    input  logic                                     i_rslt_ready,
    output logic [7:0]                               o_windowIdx,
    output logic                                     o_busy
);

    localparam int EW = $clog2(MAX_WINDOW_LENGTH_EXP + 1);  // window exponent width
    localparam int JW = $clog2(MAX_SAMPLE_JITTER_EXP + 1);  // jitter exponent width
    localparam int PW = MAX_SAMPLE_PERIOD_EXP;              // period field width
    localparam int CW = MAX_SAMPLE_PERIOD_EXP + 1;          // period counter width
    localparam int SW = MAX_WINDOW_LENGTH_EXP + 1;          // sample counter width

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAMPLING = 2'd1,
        RESULT   = 2'd2
    } state_t;

    // Per-window shadow copy of the configuration.
    typedef struct packed {
        logic [EW-1:0] win_exp;
        logic [PW-1:0] period_m1;
        logic [JW-1:0] jit_exp;
    } cfg_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Low jit_exp bits of the LFSR, zero-extended to counter width.
    function automatic logic [CW-1:0] jitter_of(input logic [15:0] lfsr,
                                                 input logic [JW-1:0] jit_exp);
        logic [CW-1:0] jit;
        jit = {CW{1'b0}};
        for (int i = 0; i < MAX_SAMPLE_JITTER_EXP; i++) begin
            if (i < int'(jit_exp)) begin
                jit[i] = lfsr[i];
            end else begin
                jit[i] = 1'b0;
            end
        end
        return jit;
    endfunction

    // Illegal window exponents are forced into 1..MAX so a window always
    // has at least two samples; start and end can then never coincide.
    function automatic logic [EW-1:0] clamp_win_exp(input logic [EW-1:0] e);
        if (e == {EW{1'b0}}) begin
            return EW'(1);
        end else if (e > EW'(MAX_WINDOW_LENGTH_EXP)) begin
            return EW'(MAX_WINDOW_LENGTH_EXP);
        end else begin
            return e;
        end
    endfunction

    // Jitter widths beyond the supported mask are limited to the maximum.
    function automatic logic [JW-1:0] clamp_jit_exp(input logic [JW-1:0] e);
        if (e > JW'(MAX_SAMPLE_JITTER_EXP)) begin
            return JW'(MAX_SAMPLE_JITTER_EXP);
        end else begin
            return e;
        end
    endfunction

    // Sample count value carried by the last strobe of a 2^e window.
    function automatic logic [SW-1:0] last_index(input logic [EW-1:0] e);
        return (SW'(1) << e) - SW'(1);
    endfunction

    // Registers
    state_t        state_r;
    cfg_t          cfg_r;
    logic [15:0]   lfsr_r;
    logic [CW-1:0] cnt_r;
    logic [SW-1:0] sample_cnt_r;
    logic          strobe_r;
    logic          start_r;
    logic          end_r;
    logic          valid_r;
    logic [7:0]    idx_r;
    logic          busy_r;

    // Next values
    state_t        state_s;
    cfg_t          cfg_s;
    logic [15:0]   lfsr_s;
    logic [CW-1:0] cnt_s;
    logic [SW-1:0] sample_cnt_s;
    logic          strobe_s;
    logic          start_s;
    logic          end_s;
    logic          valid_s;
    logic [7:0]    idx_s;
    logic          busy_s;

    // Helpers shared by the FSM branches
    cfg_t          launch_cfg_s;
    logic [CW-1:0] launch_cnt_s;
    logic [CW-1:0] reload_cnt_s;
    logic [15:0]   lfsr_adv_s;
    logic [SW-1:0] last_idx_s;
    logic          cnt_zero_s;
    logic          last_sample_s;

    // A launch reads the live config pins; reloads use the shadow copy.
    // Both take jitter from the current LFSR value, which then advances.
    assign launch_cfg_s.win_exp   = clamp_win_exp(i_cfg_windowLengthExp);
    assign launch_cfg_s.period_m1 = i_cfg_samplePeriodM1;
    assign launch_cfg_s.jit_exp   = clamp_jit_exp(i_cfg_sampleJitterExp);
    assign launch_cnt_s  = {1'b0, i_cfg_samplePeriodM1} + jitter_of(lfsr_r, launch_cfg_s.jit_exp);
    assign reload_cnt_s  = {1'b0, cfg_r.period_m1} + jitter_of(lfsr_r, cfg_r.jit_exp);
    assign lfsr_adv_s    = lfsr_step(lfsr_r);
    assign last_idx_s    = last_index(cfg_r.win_exp);
    assign cnt_zero_s    = (cnt_r == {CW{1'b0}});
    assign last_sample_s = (sample_cnt_r == last_idx_s);

    // Next-state, counter, LFSR and output decode for the sequencer FSM.
    always_comb begin
        state_s      = state_r;
        cfg_s        = cfg_r;
        lfsr_s       = lfsr_r;
        cnt_s        = cnt_r;
        sample_cnt_s = sample_cnt_r;
        strobe_s     = 1'b0;
        start_s      = 1'b0;
        end_s        = 1'b0;
        valid_s      = valid_r;
        idx_s        = idx_r;

        case (state_r)
            IDLE: begin
                if (i_cfg_enable) begin
                    state_s      = SAMPLING;
                    cfg_s        = launch_cfg_s;
                    cnt_s        = launch_cnt_s;
                    lfsr_s       = lfsr_adv_s;
                    sample_cnt_s = {SW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end

            SAMPLING: begin
                if (!i_cfg_enable) begin
                    // Abort: the partial window is dropped without a result.
                    state_s      = IDLE;
                    cnt_s        = {CW{1'b0}};
                    sample_cnt_s = {SW{1'b0}};
                end else if (cnt_zero_s) begin
                    strobe_s = 1'b1;
                    start_s  = (sample_cnt_r == {SW{1'b0}});
                    end_s    = last_sample_s;
                    cnt_s    = reload_cnt_s;
                    lfsr_s   = lfsr_adv_s;
                    if (last_sample_s) begin
                        state_s      = RESULT;
                        sample_cnt_s = {SW{1'b0}};
                    end else begin
                        sample_cnt_s = sample_cnt_r + SW'(1);
                    end
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end

            RESULT: begin
                // First RESULT cycle is the end-strobe cycle itself, so valid
                // rises one cycle later and ready is ignored until then.
                if (!valid_r) begin
                    valid_s = 1'b1;
                end else if (i_rslt_ready) begin
                    valid_s = 1'b0;
                    idx_s   = idx_r + 8'd1;
                    if (i_cfg_enable) begin
                        state_s      = SAMPLING;
                        cfg_s        = launch_cfg_s;
                        cnt_s        = launch_cnt_s;
                        lfsr_s       = lfsr_adv_s;
                        sample_cnt_s = {SW{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end

            default: begin
                state_s      = IDLE;
                valid_s      = 1'b0;
                cnt_s        = {CW{1'b0}};
                sample_cnt_s = {SW{1'b0}};
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, shadow config and registered outputs; reset overrides clock gating.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= IDLE;
            cfg_r        <= '{win_exp: EW'(1), period_m1: {PW{1'b0}}, jit_exp: {JW{1'b0}}};
            lfsr_r       <= LFSR_SEED;
            cnt_r        <= {CW{1'b0}};
            sample_cnt_r <= {SW{1'b0}};
            strobe_r     <= 1'b0;
            start_r      <= 1'b0;
            end_r        <= 1'b0;
            valid_r      <= 1'b0;
            idx_r        <= 8'd0;
            busy_r       <= 1'b0;
        end else if (i_cg) begin
            state_r      <= state_s;
            cfg_r        <= cfg_s;
            lfsr_r       <= lfsr_s;
            cnt_r        <= cnt_s;
            sample_cnt_r <= sample_cnt_s;
            strobe_r     <= strobe_s;
            start_r      <= start_s;
            end_r        <= end_s;
            valid_r      <= valid_s;
            idx_r        <= idx_s;
            busy_r       <= busy_s;
        end
    end

    assign o_sampleStrobe = strobe_r;
    assign o_windowStart  = start_r;
    assign o_windowEnd    = end_r;
    assign o_rslt_valid   = valid_r;
    assign o_windowIdx    = idx_r;
    assign o_busy         = busy_r;

endmodule

// File: tb/tb_corr_window_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for corr_window_sequencer.
// The reference model schedules strobes as absolute tick times
// (launch/strobe tick + periodM1 + jitter + 1). It is compared with the
// DUT every cycle. Directed scenarios also check hand-computed cycle offsets.
// ---------------------------------------------------------------------------
module tb_corr_window_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cg = 1'b1;
    logic        en = 1'b0;
    logic [4:0]  cfg_exp = 5'd0;
    logic [14:0] cfg_period = 15'd0;
    logic [3:0]  cfg_jexp = 4'd0;
    logic        rdy = 1'b0;
    logic        o_strobe, o_start, o_end, o_valid, o_busy;
    logic [7:0]  o_idx;

    corr_window_sequencer dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_cg                  (cg),
        .i_cfg_enable          (en),
        .i_cfg_windowLengthExp (cfg_exp),
        .i_cfg_samplePeriodM1  (cfg_period),
        .i_cfg_sampleJitterExp (cfg_jexp),
        .o_sampleStrobe        (o_strobe),
        .o_windowStart         (o_start),
        .o_windowEnd           (o_end),
        .o_rslt_valid          (o_valid),
        .i_rslt_ready          (rdy),
        .o_windowIdx           (o_idx),
        .o_busy                (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit last_cg = 1'b1;

    // event logs (cycle numbers), filled by the compare process
    int sq[$];
    int st_q[$];
    int en_q[$];
    int va_q[$];
    int ix_q[$];
    int wrap_cnt = 0;
    logic [7:0] prev_idx = 8'd0;

    // ---------------- reference model ----------------
    int m_mode = 0;   // 0 idle, 1 sampling, 2 result
    int m_tick = 0;
    int m_next = 0;
    int m_k = 0;
    int m_len = 2;
    int m_period = 0;
    int m_jexp = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    bit e_strobe, e_start, e_end, e_valid, e_busy;
    int e_idx = 0;

    task automatic m_draw(output int j);
        int mask;
        mask = (1 << m_jexp) - 1;
        j = int'(m_lfsr) & mask;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic m_launch();
        int e;
        int j;
        e = int'(cfg_exp);
        if (e < 1) e = 1;
        if (e > 16) e = 16;
        m_len = 1 << e;
        m_period = int'(cfg_period);
        m_jexp = (int'(cfg_jexp) > 8) ? 8 : int'(cfg_jexp);
        m_draw(j);
        m_next = m_tick + m_period + j + 1;
        m_k = 0;
        m_mode = 1;
    endtask

    initial forever begin
        int j;
        @(posedge clk);
        cyc++;
        last_cg = cg;
        if (rst) begin
            m_mode = 0; m_lfsr = 16'hACE1; m_tick = 0; m_k = 0;
            e_strobe = 0; e_start = 0; e_end = 0; e_valid = 0; e_busy = 0; e_idx = 0;
        end else if (cg) begin
            m_tick++;
            e_strobe = 0; e_start = 0; e_end = 0;
            case (m_mode)
                0: if (en) m_launch();
                1: begin
                    if (!en) begin
                        m_mode = 0;
                    end else if (m_tick == m_next) begin
                        e_strobe = 1;
                        e_start = (m_k == 0);
                        e_end = (m_k == m_len - 1);
                        m_k++;
                        m_draw(j);
                        m_next = m_tick + m_period + j + 1;
                        if (e_end) m_mode = 2;
                    end
                end
                default: begin
                    if (!e_valid) begin
                        e_valid = 1;
                    end else if (rdy) begin
                        e_valid = 0;
                        e_idx = (e_idx + 1) % 256;
                        if (en) m_launch();
                        else m_mode = 0;
                    end
                end
            endcase
            e_busy = (m_mode != 0);
        end
    end

    // ---------------- per-cycle compare and event logging ----------------
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            checks++;
            if (o_strobe !== e_strobe || o_start !== e_start || o_end !== e_end ||
                o_valid !== e_valid || o_busy !== e_busy || o_idx !== 8'(e_idx)) begin
                errors++;
                $display("FAIL model cyc=%0d got stb/st/end/val/busy/idx=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o_strobe, o_start, o_end, o_valid, o_busy, o_idx,
                         e_strobe, e_start, e_end, e_valid, e_busy, e_idx);
            end
            if (last_cg) begin
                if (o_strobe === 1'b1) sq.push_back(cyc);
                if (o_start === 1'b1) st_q.push_back(cyc);
                if (o_end === 1'b1) en_q.push_back(cyc);
                if (o_valid === 1'b1) va_q.push_back(cyc);
            end
            if (o_idx !== prev_idx) ix_q.push_back(cyc);
            if (prev_idx == 8'd255 && o_idx == 8'd0) wrap_cnt++;
            prev_idx = o_idx;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        else return -100000;
    endfunction

    function automatic int cnt_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; rdy = 1'b0; cg = 1'b1;
        step(2);
        sq.delete(); st_q.delete(); en_q.delete(); va_q.delete(); ix_q.delete();
        wrap_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic start_run(input int p, input int jx, input int ex, input bit r, output int acc);
        cfg_period = 15'(p); cfg_jexp = 4'(jx); cfg_exp = 5'(ex); rdy = r; en = 1'b1;
        acc = cyc + 1;
    endtask

    task automatic timeout(input string name, input int budget);
        checks++; errors++;
        $display("FAIL %s timeout after %0d cycles", name, budget);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (o_valid !== 1'b1 && n < budget) begin @(negedge clk); #1; n++; end
        if (o_valid !== 1'b1) timeout(name, budget);
    endtask

    task automatic wait_strobes(input string name, input int num, input int budget);
        int n = 0;
        while (sq.size() < num && n < budget) begin @(negedge clk); #1; n++; end
        if (sq.size() < num) timeout(name, budget);
    endtask

    task automatic wait_idx(input string name, input int budget);
        int n = 0;
        while (ix_q.size() < 1 && n < budget) begin @(negedge clk); #1; n++; end
        if (ix_q.size() < 1) timeout(name, budget);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int acc, acc2, v;
        int pinned[6] = '{5, 9, 13, 17, 23, 30};

        // reset state
        do_reset();
        #1;
        chk("reset_outputs", int'({o_strobe, o_start, o_end, o_valid, o_busy}), 0);
        chk("reset_idx", int'(o_idx), 0);

        // basic framing
        do_reset();
        start_run(3, 0, 2, 1'b1, acc);
        step(31); #1;
        chk("basic_strobe1", qget(sq, 0) - acc, 4);
        chk("basic_strobe2", qget(sq, 1) - acc, 8);
        chk("basic_strobe3", qget(sq, 2) - acc, 12);
        chk("basic_strobe4", qget(sq, 3) - acc, 16);
        chk("basic_start", qget(st_q, 0) - acc, 4);
        chk("basic_end", qget(en_q, 0) - acc, 16);
        chk("basic_valid_count", va_q.size(), 1);
        chk("basic_valid_cycle", qget(va_q, 0) - acc, 17);
        chk("basic_idx_change", qget(ix_q, 0) - acc, 18);
        chk("basic_next_window", qget(sq, 4) - acc, 22);

        // backpressure
        do_reset();
        start_run(3, 0, 2, 1'b0, acc);
        wait_valid("bp_wait_valid", 60);
        v = cyc;
        chk("bp_valid_rise", v - acc, 17);
        step(9);
        rdy = 1'b1;
        step(1); #1;
        chk("bp_valid_cycles", cnt_in(va_q, v, v + 10), 10);
        chk("bp_no_strobes", cnt_in(sq, v, v + 10), 0);
        chk("bp_valid_dropped", int'(o_valid), 0);
        chk("bp_idx", int'(o_idx), 1);
        chk("bp_single_transfer", ix_q.size(), 1);

        // jitter against hand-stepped LFSR from seed
        do_reset();
        start_run(3, 2, 4, 1'b1, acc);
        step(130); #1;
        for (int i = 0; i < 6; i++) chk($sformatf("jit_offset%0d", i), qget(sq, i) - acc, pinned[i]);
        for (int i = 1; i < 16; i++) begin
            int d;
            d = qget(sq, i) - qget(sq, i - 1);
            chk($sformatf("jit_interval%0d_in_range", i), int'(d >= 4 && d <= 7), 1);
        end

        // abort after the second strobe
        do_reset();
        start_run(3, 0, 2, 1'b1, acc);
        wait_strobes("abort_wait", 2, 40);
        en = 1'b0;
        step(20); #1;
        chk("abort_strobes", sq.size(), 2);
        chk("abort_no_valid", va_q.size(), 0);
        chk("abort_idx", int'(o_idx), 0);
        chk("abort_busy", int'(o_busy), 0);
        en = 1'b1;
        acc2 = cyc + 1;
        step(6); #1;
        chk("abort_restart_start", qget(st_q, 1) - acc2, 4);

        // config isolation: period change mid-window
        do_reset();
        start_run(3, 0, 2, 1'b1, acc);
        step(1);
        cfg_period = 15'd9;
        step(45); #1;
        chk("iso_interval_a", qget(sq, 1) - qget(sq, 0), 4);
        chk("iso_interval_b", qget(sq, 3) - qget(sq, 2), 4);
        chk("iso_next_first", qget(sq, 4) - acc, 28);
        chk("iso_next_interval", qget(sq, 5) - qget(sq, 4), 10);

        // exp=0 clamps to 2-sample windows
        do_reset();
        start_run(1, 0, 0, 1'b1, acc);
        step(10); #1;
        chk("clamp_start", qget(st_q, 0) - acc, 2);
        chk("clamp_end", qget(en_q, 0) - acc, 4);

        // reset while a result is pending
        do_reset();
        start_run(3, 0, 2, 1'b1, acc);
        wait_idx("rst_wait_idx", 60);
        rdy = 1'b0;
        wait_valid("rst_wait_valid", 60);
        rst = 1'b1;
        step(1); #1;
        chk("rst_result_outputs", int'({o_strobe, o_start, o_end, o_valid, o_busy}), 0);
        chk("rst_result_idx", int'(o_idx), 0);
        rst = 1'b0;

        // clock gate low for 5 cycles after the first strobe
        do_reset();
        start_run(3, 0, 2, 1'b1, acc);
        wait_strobes("cg_wait", 1, 40);
        cg = 1'b0;
        step(5);
        cg = 1'b1;
        step(20); #1;
        chk("cg_strobe1", qget(sq, 0) - acc, 4);
        chk("cg_strobe2", qget(sq, 1) - acc, 13);
        chk("cg_strobe3", qget(sq, 2) - acc, 17);

        // 300+ windows: index wraps once
        do_reset();
        start_run(0, 0, 1, 1'b1, acc);
        step(1230); #1;
        chk("wrap_count", wrap_cnt, 1);
        chk("wrap_final_idx", int'(o_idx), 51);

        en = 1'b0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
